// File: rtl/sigma_delta_pipe.sv
// Pipelined per-pixel sigma-delta background/variance update with a motion flag,
// frame-rate decimation of model updates and a per-frame motion-pixel counter.
// Stage 1 registers the beat and |pixel - background|; stage 2 registers the results.
module sigma_delta_pipe #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned N_SCALE   = 2,
  parameter int unsigned VAR_MIN   = 2,
  parameter int unsigned VAR_MAX   = (1 << PIX_W) - 1,
  parameter int unsigned VAR_STEP  = 2,
  parameter int unsigned RATE_LOG2 = 0,
  parameter int unsigned CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic             in_init,
  input  logic [PIX_W-1:0] curr_pixel,
  input  logic [PIX_W-1:0] background,
  input  logic [PIX_W-1:0] variance,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic [PIX_W-1:0] background_next,
  output logic [PIX_W-1:0] variance_next,
  output logic             motion_detected,
  output logic [CNT_W-1:0] frame_motion_count,
  output logic             frame_count_valid
);

  // N_SCALE <= 15, so four extra bits hold N_SCALE*diff without truncation.
  localparam int unsigned M_W  = PIX_W + 4;
  // A zero-width frame counter is not legal; keep one bit and ignore it when RATE_LOG2 == 0.
  localparam int unsigned FI_W = (RATE_LOG2 > 0) ? RATE_LOG2 : 1;

  localparam logic [PIX_W:0] STEP_X = (PIX_W + 1)'(VAR_STEP);
  localparam logic [PIX_W:0] MIN_X  = (PIX_W + 1)'(VAR_MIN);
  localparam logic [PIX_W:0] MAX_X  = (PIX_W + 1)'(VAR_MAX);

  // Handshake: stage 2 frees up when empty or drained; stage 1 follows stage 2.
  logic s1_valid;
  logic s2_load;
  logic s1_load;
  logic accept;
  logic out_xfer;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Frame index: the sof beat itself already belongs to the new frame.
  logic [FI_W-1:0] frame_idx_q;
  logic [FI_W-1:0] frame_idx_d;
  logic            upd;
  logic [PIX_W-1:0] diff;

  // Next frame index, update-frame decision and absolute difference for the incoming beat.
  always_comb begin
    frame_idx_d = frame_idx_q;
    if (accept && in_sof) begin
      frame_idx_d = frame_idx_q + FI_W'(1);
    end
    upd  = (RATE_LOG2 == 0) ? 1'b1 : (frame_idx_d == '0);
    diff = (curr_pixel >= background) ? (curr_pixel - background) : (background - curr_pixel);
  end

  // Frame index register; all-ones at reset so the first frame is an update frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_idx_q <= '1;
    end else begin
      frame_idx_q <= frame_idx_d;
    end
  end

  logic [PIX_W-1:0] s1_pix;
  logic [PIX_W-1:0] s1_bg;
  logic [PIX_W-1:0] s1_var;
  logic [PIX_W-1:0] s1_diff;
  logic             s1_init;
  logic             s1_sof;
  logic             s1_upd;

  // Stage 1: capture the accepted beat together with its diff and update decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_bg    <= '0;
      s1_var   <= '0;
      s1_diff  <= '0;
      s1_init  <= 1'b0;
      s1_sof   <= 1'b0;
      s1_upd   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_pix  <= curr_pixel;
        s1_bg   <= background;
        s1_var  <= variance;
        s1_diff <= diff;
        s1_init <= in_init;
        s1_sof  <= in_sof;
        s1_upd  <= upd;
      end
    end
  end

  logic [M_W-1:0]   m_scaled;
  logic [M_W-1:0]   var_m;
  logic [PIX_W:0]   var_x;
  logic [PIX_W:0]   var_inc;
  logic [PIX_W:0]   var_dec;
  logic [PIX_W:0]   var_n;
  logic [PIX_W-1:0] bg_n;
  logic             mot_n;

  // Stage 2 next values: background tracking, clamped variance step, motion flag.
  always_comb begin
    m_scaled = M_W'(N_SCALE) * M_W'(s1_diff);
    var_m    = M_W'(s1_var);
    var_x    = {1'b0, s1_var};
    var_inc  = var_x + STEP_X;
    // Below zero collapses to zero; the floor clamp then lifts it to VAR_MIN.
    var_dec  = (var_x < STEP_X) ? '0 : (var_x - STEP_X);
    mot_n    = !s1_init && (s1_diff >= s1_var);
    bg_n     = s1_bg;
    var_n    = var_x;
    if (s1_init) begin
      bg_n  = s1_pix;
      var_n = MIN_X;
    end else if (s1_upd) begin
      if (s1_pix > s1_bg) begin
        bg_n = (s1_bg == '1) ? s1_bg : (s1_bg + 1'b1);
      end else if (s1_pix < s1_bg) begin
        bg_n = (s1_bg == '0) ? s1_bg : (s1_bg - 1'b1);
      end
      if (m_scaled != var_m) begin
        var_n = (m_scaled > var_m) ? var_inc : var_dec;
        if (var_n > MAX_X) begin
          var_n = MAX_X;
        end else if (var_n < MIN_X) begin
          var_n = MIN_X;
        end
      end
    end
  end

  // Stage 2 output register; data only moves when a real beat advances, so stalls hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_sof         <= 1'b0;
      background_next <= '0;
      variance_next   <= MIN_X[PIX_W-1:0];
      motion_detected <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sof         <= s1_sof;
        background_next <= bg_n;
        variance_next   <= var_n[PIX_W-1:0];
        motion_detected <= mot_n;
      end
    end
  end

  logic [CNT_W-1:0] run_cnt_q;
  logic             seen_q;

  // Motion counter: publish the running count at each transferred sof beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_q          <= '0;
      seen_q             <= 1'b0;
      frame_motion_count <= '0;
      frame_count_valid  <= 1'b0;
    end else begin
      frame_count_valid <= 1'b0;
      if (out_xfer) begin
        seen_q <= 1'b1;
        if (out_sof) begin
          frame_count_valid <= 1'b1;
          // Nothing to publish before the first beat since reset.
          if (seen_q) begin
            frame_motion_count <= run_cnt_q;
          end
          run_cnt_q <= CNT_W'(motion_detected);
        end else if (motion_detected && (run_cnt_q != '1)) begin
          run_cnt_q <= run_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_pipe.sv
// Directed bench for sigma_delta_pipe: three instances share one stimulus stream
// (a: N_SCALE=1, b: N_SCALE=2, c: N_SCALE=1 with RATE_LOG2=1).
module tb_sigma_delta_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof, in_init, out_ready;
  logic [7:0] curr_pixel, background, variance;

  logic        a_in_ready, a_out_valid, a_out_sof, a_mot, a_fcv;
  logic [7:0]  a_bg, a_var;
  logic [19:0] a_fmc;
  logic        b_in_ready, b_out_valid, b_out_sof, b_mot, b_fcv;
  logic [7:0]  b_bg, b_var;
  logic [19:0] b_fmc;
  logic        c_in_ready, c_out_valid, c_out_sof, c_mot, c_fcv;
  logic [7:0]  c_bg, c_var;
  logic [19:0] c_fmc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sigma_delta_pipe #(.N_SCALE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_sof(in_sof),
    .in_init(in_init), .curr_pixel(curr_pixel), .background(background), .variance(variance),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sof(a_out_sof),
    .background_next(a_bg), .variance_next(a_var), .motion_detected(a_mot),
    .frame_motion_count(a_fmc), .frame_count_valid(a_fcv)
  );

  sigma_delta_pipe #(.N_SCALE(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_sof(in_sof),
    .in_init(in_init), .curr_pixel(curr_pixel), .background(background), .variance(variance),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sof(b_out_sof),
    .background_next(b_bg), .variance_next(b_var), .motion_detected(b_mot),
    .frame_motion_count(b_fmc), .frame_count_valid(b_fcv)
  );

  sigma_delta_pipe #(.N_SCALE(1), .RATE_LOG2(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_sof(in_sof),
    .in_init(in_init), .curr_pixel(curr_pixel), .background(background), .variance(variance),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_sof(c_out_sof),
    .background_next(c_bg), .variance_next(c_var), .motion_detected(c_mot),
    .frame_motion_count(c_fmc), .frame_count_valid(c_fcv)
  );

  // Reference update for an 8-bit pixel, VAR_MIN=2, VAR_MAX=255, VAR_STEP=2: {bg, var, motion}.
  function automatic logic [16:0] model(input logic [7:0] p, input logic [7:0] b,
                                        input logic [7:0] v, input logic init, input int n);
    int d, m, bn, vn;
    logic mot;
    d   = (p > b) ? int'(p) - int'(b) : int'(b) - int'(p);
    m   = n * d;
    mot = !init && (d >= int'(v));
    bn  = int'(b);
    vn  = int'(v);
    if (init) begin
      bn = int'(p);
      vn = 2;
    end else begin
      if (p > b && b != 8'd255) bn = int'(b) + 1;
      if (p < b && b != 8'd0)   bn = int'(b) - 1;
      if (m != int'(v)) begin
        vn = (m > int'(v)) ? int'(v) + 2 : int'(v) - 2;
        if (vn > 255) vn = 255;
        if (vn < 2)   vn = 2;
      end
    end
    return {bn[7:0], vn[7:0], mot};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_init = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send one beat into an empty pipe and wait (bounded) for it to reach the outputs.
  task automatic xfer(input logic [7:0] p, input logic [7:0] b, input logic [7:0] v,
                      input logic s, input logic i, output int lat);
    @(negedge clk);
    curr_pixel = p; background = b; variance = v; in_sof = s; in_init = i;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_init = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({a_out_valid, a_out_sof, a_mot, a_fcv} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {a_out_valid, a_out_sof, a_mot, a_fcv});
    end
    n_vec++;
    if ({a_bg, a_var} !== {8'd0, 8'd2}) begin
      n_bad++; $display("FAIL reset_model got bg=%0d var=%0d want bg=0 var=2", a_bg, a_var);
    end
    n_vec++;
    if ({a_fmc, a_in_ready} !== {20'd0, 1'b1}) begin
      n_bad++; $display("FAIL reset_count got fmc=%0d in_ready=%b want 0,1", a_fmc, a_in_ready);
    end
    do_reset();
  endtask

  task automatic test_streaming();
    int lat;
    xfer(8'd100, 8'd90, 8'd5, 1'b1, 1'b0, lat);
    n_vec++;
    if (lat !== 2) begin n_bad++; $display("FAIL stream_latency got %0d want 2", lat); end
    n_vec++;
    if ({a_bg, a_var, a_mot} !== {8'd91, 8'd7, 1'b1}) begin
      n_bad++; $display("FAIL stream_up got %0d/%0d/%b want 91/7/1", a_bg, a_var, a_mot);
    end
    xfer(8'd90, 8'd90, 8'd5, 1'b0, 1'b0, lat);
    n_vec++;
    if ({a_bg, a_var, a_mot} !== {8'd90, 8'd3, 1'b0}) begin
      n_bad++; $display("FAIL stream_eq got %0d/%0d/%b want 90/3/0", a_bg, a_var, a_mot);
    end
  endtask

  task automatic test_saturation();
    int lat;
    xfer(8'd255, 8'd255, 8'd254, 1'b0, 1'b0, lat);
    n_vec++;
    if ({a_bg, a_var, a_mot} !== {8'd255, 8'd252, 1'b0}) begin
      n_bad++; $display("FAIL sat_top got %0d/%0d/%b want 255/252/0", a_bg, a_var, a_mot);
    end
    xfer(8'd0, 8'd0, 8'd3, 1'b0, 1'b0, lat);
    n_vec++;
    if ({a_bg, a_var, a_mot} !== {8'd0, 8'd2, 1'b0}) begin
      n_bad++; $display("FAIL sat_floor got %0d/%0d/%b want 0/2/0", a_bg, a_var, a_mot);
    end
    xfer(8'd255, 8'd0, 8'd254, 1'b0, 1'b0, lat);
    n_vec++;
    if ({a_bg, a_var, a_mot} !== {8'd1, 8'd255, 1'b1}) begin
      n_bad++; $display("FAIL sat_ceil got %0d/%0d/%b want 1/255/1", a_bg, a_var, a_mot);
    end
  endtask

  task automatic test_scale();
    int lat;
    xfer(8'd13, 8'd10, 8'd5, 1'b0, 1'b0, lat);
    n_vec++;
    if ({b_bg, b_var, b_mot} !== {8'd11, 8'd7, 1'b0}) begin
      n_bad++; $display("FAIL scale_n2 got %0d/%0d/%b want 11/7/0", b_bg, b_var, b_mot);
    end
    n_vec++;
    if ({a_bg, a_var, a_mot} !== {8'd11, 8'd3, 1'b0}) begin
      n_bad++; $display("FAIL scale_n1 got %0d/%0d/%b want 11/3/0", a_bg, a_var, a_mot);
    end
    xfer(8'd77, 8'd10, 8'd50, 1'b0, 1'b1, lat);
    n_vec++;
    if ({b_bg, b_var, b_mot} !== {8'd77, 8'd2, 1'b0}) begin
      n_bad++; $display("FAIL init_beat got %0d/%0d/%b want 77/2/0", b_bg, b_var, b_mot);
    end
  endtask

  task automatic test_decimation();
    int lat;
    logic [16:0] want [4];
    want[0] = {8'd41, 8'd7, 1'b1};
    want[1] = {8'd40, 8'd5, 1'b1};
    want[2] = {8'd41, 8'd7, 1'b1};
    want[3] = {8'd40, 8'd5, 1'b1};
    do_reset();
    for (int f = 0; f < 4; f++) begin
      xfer(8'd50, 8'd40, 8'd5, 1'b1, 1'b0, lat);
      n_vec++;
      if ({c_bg, c_var, c_mot} !== want[f]) begin
        n_bad++;
        $display("FAIL decim_frame%0d got %0d/%0d/%b want %0d/%0d/%b", f, c_bg, c_var, c_mot,
                 want[f][16:9], want[f][8:1], want[f][0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp_q[$];
    logic [17:0] held, e;
    bit stall, acc;
    int sent, got, cyc;
    do_reset();
    sent = 0; got = 0; cyc = 0; stall = 0; acc = 0;
    while (got < 1000 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        n_vec++;
        if ({b_out_valid, b_out_sof, b_bg, b_var, b_mot} !== {1'b1, held}) begin
          n_bad++;
          $display("FAIL bp_stall_hold got %b want %b", {b_out_valid, b_out_sof, b_bg, b_var, b_mot},
                   {1'b1, held});
        end
      end
      if (acc || !in_valid) begin
        if (sent < 1000 && $urandom_range(0, 9) < 9) begin
          curr_pixel = 8'($urandom_range(0, 255));
          background = 8'($urandom_range(0, 255));
          variance   = 8'($urandom_range(0, 255));
          in_sof     = ($urandom_range(0, 9) == 0);
          in_init    = ($urandom_range(0, 9) == 0);
          in_valid   = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) >= 3);
      #1;
      acc = in_valid && b_in_ready;
      if (acc) begin
        exp_q.push_back({in_sof, model(curr_pixel, background, variance, in_init, 2)});
        sent++;
      end
      if (b_out_valid && out_ready) begin
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_beat got beat %0d want none", got);
        end else begin
          e = exp_q.pop_front();
          if ({b_out_sof, b_bg, b_var, b_mot} !== e) begin
            n_bad++;
            $display("FAIL bp_beat%0d got %b want %b", got, {b_out_sof, b_bg, b_var, b_mot}, e);
          end
        end
      end
      stall = b_out_valid && !out_ready;
      held  = {b_out_sof, b_bg, b_var, b_mot};
    end
    n_vec++;
    if (got != 1000 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL bp_total got %0d left %0d want 1000 left 0", got, exp_q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_motion_count();
    int pulses, ov;
    int pv [4];
    bit mot;
    do_reset();
    pulses = 0; ov = 0;
    // 16-beat frame with motion at beats 2,5,7,11,14, then one sof beat; sampled every cycle.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (a_fcv) begin
        if (pulses < 4) pv[pulses] = int'(a_fmc);
        pulses++;
      end
      if (a_out_valid) ov++;
      if (i < 17) begin
        mot        = (i == 2 || i == 5 || i == 7 || i == 11 || i == 14);
        curr_pixel = mot ? 8'd100 : 8'd60;
        background = mot ? 8'd90 : 8'd60;
        variance   = 8'd5;
        in_sof     = (i == 0 || i == 16);
        in_init    = 1'b0;
        in_valid   = 1'b1;
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
    end
    n_vec++;
    if (ov !== 17) begin n_bad++; $display("FAIL b2b_out_cycles got %0d want 17", ov); end
    n_vec++;
    if (pulses !== 2) begin n_bad++; $display("FAIL cnt_pulses got %0d want 2", pulses); end
    n_vec++;
    if (pulses >= 2 && (pv[0] !== 0 || pv[1] !== 5)) begin
      n_bad++; $display("FAIL cnt_values got %0d,%0d want 0,5", pv[0], pv[1]);
    end
    n_vec++;
    if (a_fmc !== 20'd5) begin n_bad++; $display("FAIL cnt_hold got %0d want 5", a_fmc); end
    // Mid-frame reset: pipeline full of motion beats.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      curr_pixel = 8'd100; background = 8'd90; variance = 8'd5;
      in_sof = (i == 0); in_valid = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({a_out_valid, a_fmc, a_fcv, a_in_ready} !== {1'b0, 20'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midreset got valid=%b fmc=%0d fcv=%b rdy=%b want 0,0,0,1", a_out_valid, a_fmc,
               a_fcv, a_in_ready);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_init = 1'b0; out_ready = 1'b1;
    curr_pixel = '0; background = '0; variance = '0;
    test_reset();
    test_streaming();
    test_saturation();
    test_scale();
    test_decimation();
    test_backpressure();
    test_motion_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
